// File: rtl/ibex_pkg.sv
// Shared types and constants for the Ascon execution unit.
package ibex_pkg;

    // Operations understood by the Ascon unit
    typedef enum logic [1:0] {
        ASCON_OP_WR,
        ASCON_OP_RD,
        ASCON_OP_PERM,
        ASCON_OP_CLR
    } ascon_op_e;

    // Control states of the permutation sequencer
    typedef enum logic [1:0] {
        ASCON_IDLE,
        ASCON_PERM,
        ASCON_DONE
    } ascon_fsm_e;

    parameter int unsigned ASCON_ROUNDS_MAX = 12;
    localparam int unsigned ASCON_NUM_WORDS = 10;

    // Decoder helper: funct3 of OPCODE_ASCON to unit operation
    function automatic ascon_op_e ascon_op_from_funct3(input logic [2:0] funct3);
        ascon_op_e op;
        case (funct3)
            3'b000:  op = ASCON_OP_WR;
            3'b001:  op = ASCON_OP_RD;
            3'b010:  op = ASCON_OP_PERM;
            3'b011:  op = ASCON_OP_CLR;
            default: op = ASCON_OP_RD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ibex_ascon_round.sv
// One Ascon round (constant addition, S-box, linear layer); purely combinational.
module ibex_ascon_round (
    input  logic [319:0] state_i,
    input  logic [3:0]   k_i,
    output logic [319:0] state_o
);

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    logic [63:0] x [5];
    logic [63:0] t [5];
    logic [63:0] s [5];

    // Full round on the five 64-bit lanes
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            x[i] = state_i[64*i +: 64];
        end
        x[2] = x[2] ^ {56'd0, 4'hF - k_i, k_i};
        x[0] = x[0] ^ x[4];
        x[4] = x[4] ^ x[3];
        x[2] = x[2] ^ x[1];
        for (int j = 0; j < 5; j++) begin
            t[j] = ~x[j] & x[(j + 1) % 5];
        end
        for (int j = 0; j < 5; j++) begin
            x[j] = x[j] ^ t[(j + 1) % 5];
        end
        x[1] = x[1] ^ x[0];
        x[0] = x[0] ^ x[4];
        x[3] = x[3] ^ x[2];
        x[2] = ~x[2];
        s[0] = x[0] ^ ror64(x[0], 19) ^ ror64(x[0], 28);
        s[1] = x[1] ^ ror64(x[1], 61) ^ ror64(x[1], 39);
        s[2] = x[2] ^ ror64(x[2], 1)  ^ ror64(x[2], 6);
        s[3] = x[3] ^ ror64(x[3], 10) ^ ror64(x[3], 17);
        s[4] = x[4] ^ ror64(x[4], 7)  ^ ror64(x[4], 41);
        state_o = {s[4], s[3], s[2], s[1], s[0]};
    end

endmodule

// File: rtl/ibex_ascon_unit.sv
// Ascon execution unit: 320-bit state, word access and p^a at one round per cycle.
module ibex_ascon_unit
    import ibex_pkg::*;
#(
    parameter int unsigned RoundsMax = ASCON_ROUNDS_MAX
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ascon_en_i,
    input  ascon_op_e   ascon_op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        busy_o
);

    // Requested round count clamped to what the unit supports
    function automatic logic [3:0] sat_rounds(input logic [3:0] req);
        if (32'(req) > RoundsMax) begin
            return 4'(RoundsMax);
        end
        return req;
    endfunction

    logic [9:0][31:0] state_q, state_d;
    logic [319:0]     round_out;
    logic [3:0]       round_k;
    ascon_fsm_e       fsm_q, fsm_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       nrounds_q, nrounds_d;
    logic [3:0]       n_req;
    logic [3:0]       word_idx;
    logic             word_ok;
    logic             unused_operand_b;

    assign n_req            = sat_rounds(operand_a_i[3:0]);
    assign word_idx         = operand_b_i[3:0];
    assign word_ok          = word_idx < 4'(ASCON_NUM_WORDS);
    assign unused_operand_b = ^operand_b_i[31:4];

    ibex_ascon_round u_round (
        .state_i (state_q),
        .k_i     (round_k),
        .state_o (round_out)
    );

    // Next-state, datapath select and handshake outputs
    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        nrounds_d = nrounds_q;
        state_d   = state_q;
        valid_o   = 1'b0;
        busy_o    = 1'b0;
        result_o  = 32'd0;
        round_k   = 4'd12 - n_req;
        case (fsm_q)
            ASCON_IDLE: begin
                if (ascon_en_i) begin
                    case (ascon_op_i)
                        ASCON_OP_WR: begin
                            valid_o = 1'b1;
                            if (word_ok) begin
                                state_d[word_idx] = operand_a_i;
                            end
                        end
                        ASCON_OP_RD: begin
                            valid_o = 1'b1;
                            if (word_ok) begin
                                result_o = state_q[word_idx];
                            end
                        end
                        ASCON_OP_CLR: begin
                            valid_o = 1'b1;
                            state_d = '0;
                        end
                        default: begin
                            if (n_req == 4'd0) begin
                                valid_o = 1'b1;
                            end else begin
                                busy_o    = 1'b1;
                                state_d   = round_out;
                                cnt_d     = 4'd1;
                                nrounds_d = n_req;
                                fsm_d     = (n_req > 4'd1) ? ASCON_PERM : ASCON_DONE;
                            end
                        end
                    endcase
                end
            end
            ASCON_PERM: begin
                busy_o  = 1'b1;
                round_k = 4'd12 - nrounds_q + cnt_q;
                if (ascon_en_i) begin
                    state_d = round_out;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == nrounds_q - 4'd1) begin
                        fsm_d = ASCON_DONE;
                    end
                end else begin
                    // Abort: completed rounds stay in the state
                    fsm_d = ASCON_IDLE;
                end
            end
            ASCON_DONE: begin
                valid_o = 1'b1;
                fsm_d   = ASCON_IDLE;
            end
            default: begin
                fsm_d = ASCON_IDLE;
            end
        endcase
    end

    // State, sequencer and round counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= '0;
            fsm_q     <= ASCON_IDLE;
            cnt_q     <= 4'd0;
            nrounds_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            nrounds_q <= nrounds_d;
        end
    end

    // Only PERM may be presented while a permutation is running
    always_ff @(posedge clk_i) begin
        if (rst_ni && fsm_q == ASCON_PERM && ascon_en_i) begin
            assert (ascon_op_i == ASCON_OP_PERM);
        end
    end

endmodule

// File: tb/tb_ibex_ascon_unit.sv
// Directed bench for ibex_ascon_unit with a bench-side Ascon reference.
module tb_ibex_ascon_unit;
    import ibex_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    ascon_op_e   op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] result;
    logic        valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ibex_ascon_unit #(.RoundsMax(12)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ascon_en_i  (en),
        .ascon_op_i  (op),
        .operand_a_i (opa),
        .operand_b_i (opb),
        .result_o    (result),
        .valid_o     (valid),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        ascon_op_e   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        vld;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ref_round(input logic [319:0] s, input logic [3:0] k);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x4, x3, x2, x1, x0} = s;
        x2 = x2 ^ {56'd0, 4'hF - k, k};
        x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
        x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
        logic [319:0] r;
        r = s;
        for (int i = 0; i < n; i++) begin
            r = ref_round(r, 4'(12 - n + i));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input ascon_op_e o, input logic [31:0] a, input logic [31:0] b);
        en = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic read_word(input int idx, output logic [31:0] data, output logic v);
        en = 1'b1; op = ASCON_OP_RD; opa = 32'd0; opb = 32'(idx);
        @(negedge clk);
        data = result;
        v = valid;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [319:0] exp);
        logic [31:0] d;
        logic        v;
        for (int i = 0; i < 10; i++) begin
            read_word(i, d, v);
            chk($sformatf("%s word%0d", tag, i), d, exp[32*i +: 32]);
            chk($sformatf("%s rd_valid%0d", tag, i), 32'(v), 32'd1);
        end
    endtask

    task automatic perm_run(input string tag, input logic [31:0] a, input int n);
        en = 1'b1; op = ASCON_OP_PERM; opa = a; opb = 32'd0;
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c < n));
            chk($sformatf("%s valid c%0d", tag, c), 32'(valid), 32'(c == n));
            @(posedge clk); #1;
        end
        en = 1'b0;
        @(negedge clk);
        chk({tag, " valid after"}, 32'(valid), 32'd0);
        chk({tag, " busy after"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [319:0] cur;
        logic [319:0] pat;
        logic [31:0]  d;
        logic         v;

        vecs[0]  = '{ASCON_OP_WR,  32'hDEADBEEF, 32'd3,          32'h0,        1'b1};
        vecs[1]  = '{ASCON_OP_RD,  32'h0,        32'd3,          32'hDEADBEEF, 1'b1};
        vecs[2]  = '{ASCON_OP_RD,  32'h0,        32'd12,         32'h0,        1'b1};
        vecs[3]  = '{ASCON_OP_WR,  32'hCAFEF00D, 32'd12,         32'h0,        1'b1};
        vecs[4]  = '{ASCON_OP_RD,  32'h0,        32'd3,          32'hDEADBEEF, 1'b1};
        vecs[5]  = '{ASCON_OP_WR,  32'hA5A5A5A5, 32'd0,          32'h0,        1'b1};
        vecs[6]  = '{ASCON_OP_RD,  32'h0,        32'd0,          32'hA5A5A5A5, 1'b1};
        vecs[7]  = '{ASCON_OP_WR,  32'h0F0F1234, 32'hFFFFFFF9,   32'h0,        1'b1};
        vecs[8]  = '{ASCON_OP_RD,  32'h0,        32'h00000019,   32'h0F0F1234, 1'b1};
        vecs[9]  = '{ASCON_OP_RD,  32'h0,        32'd15,         32'h0,        1'b1};
        vecs[10] = '{ASCON_OP_CLR, 32'h0,        32'd0,          32'h0,        1'b1};
        vecs[11] = '{ASCON_OP_RD,  32'h0,        32'd3,          32'h0,        1'b1};

        rst_n = 1'b0; en = 1'b0; op = ASCON_OP_WR; opa = 32'd0; opb = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_state("reset state", 320'd0);

        // Back-to-back single-cycle ops from the table
        for (int i = 0; i < 12; i++) begin
            en = 1'b1; op = vecs[i].op; opa = vecs[i].a; opb = vecs[i].b;
            @(negedge clk);
            chk($sformatf("vec%0d result", i), result, vecs[i].res);
            chk($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].vld));
            @(posedge clk); #1;
        end
        en = 1'b0;

        // Out-of-range write leaves all ten words alone
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            pat[32*i +: 32] = 32'h10000000 + 32'(i) * 32'h00011111;
            do_op(ASCON_OP_WR, pat[32*i +: 32], 32'(i));
        end
        do_op(ASCON_OP_WR, 32'hFFFFFFFF, 32'd12);
        check_state("wr idx12", pat);

        // Single round from zero, hand-computed words
        do_op(ASCON_OP_CLR, 32'd0, 32'd0);
        perm_run("perm1", 32'd1, 1);
        read_word(0, d, v); chk("perm1 word0", d, 32'h0000004B);
        read_word(1, d, v); chk("perm1 word1", d, 32'h000964B0);
        read_word(6, d, v); chk("perm1 word6", d, 32'h0000004B);
        read_word(7, d, v); chk("perm1 word7", d, 32'h12E58000);
        read_word(8, d, v); chk("perm1 word8", d, 32'h00000000);
        read_word(9, d, v); chk("perm1 word9", d, 32'h00000000);
        cur = ref_perm(320'd0, 1);

        // Zero rounds: immediate valid, no state change
        perm_run("perm0", 32'd0, 0);
        check_state("perm0", cur);

        // Request of 15 saturates to 12
        perm_run("perm15", 32'hABCDEF0F, 12);
        cur = ref_perm(cur, 12);
        check_state("perm15", cur);

        // Full p^12 from zero
        do_op(ASCON_OP_CLR, 32'd0, 32'd0);
        perm_run("perm12", 32'd12, 12);
        check_state("perm12", ref_perm(320'd0, 12));

        // Abort: en dropped in cycle 3 after rounds k=0,1,2
        do_op(ASCON_OP_CLR, 32'd0, 32'd0);
        en = 1'b1; op = ASCON_OP_PERM; opa = 32'd12; opb = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort busy c%0d", c), 32'(busy), 32'd1);
            chk($sformatf("abort valid c%0d", c), 32'(valid), 32'd0);
            @(posedge clk); #1;
        end
        en = 1'b0;
        @(negedge clk);
        chk("abort valid c3", 32'(valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort busy c4", 32'(busy), 32'd0);
        chk("abort valid c4", 32'(valid), 32'd0);
        @(posedge clk); #1;
        cur = ref_round(ref_round(ref_round(320'd0, 4'd0), 4'd1), 4'd2);
        check_state("abort", cur);

        // Reset in cycle 5 of a PERM
        do_op(ASCON_OP_WR, 32'hFFFFFFFF, 32'd4);
        en = 1'b1; op = ASCON_OP_PERM; opa = 32'd12; opb = 32'd0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst busy before", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0; en = 1'b0;
        #1;
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst result", result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_state("after rst", 320'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibex_ascon_unit.md
# ibex_ascon_unit

Multi-cycle execution unit for the custom `OPCODE_ASCON` (7'h0b) instructions. It sits in the EX stage beside the ALU and multdiv unit, is fed by the decoder, and returns results to the same writeback mux.

It holds one 320-bit Ascon state as five 64-bit lanes x0..x4. It supports word read, word write and clear of that state, and runs the Ascon permutation p^a at one round per cycle.

## Interface

Parameters:
- `RoundsMax`, default 12: maximum rounds per PERM; larger requests saturate to this value.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `ascon_en_i` in 1: request valid; held high by the core until `valid_o`; early deassertion aborts.
- `ascon_op_i` in 2 (`ascon_op_e`): operation.
- `operand_a_i` in 32: write data (WR) or round count in [3:0] (PERM).
- `operand_b_i` in 32: word index in [3:0] (WR/RD); other bits ignored.
- `result_o` out 32: read data; 0 for all other ops.
- `valid_o` out 1: result valid / operation complete.
- `busy_o` out 1: permutation in progress; used for stall.

## Operation

- Word map: index i in 0..9 selects lane x[i>>1]; i[0]=0 selects bits [31:0], i[0]=1 selects [63:32]. Index 10..15: WR ignored, RD returns 0.
- Ops (`ascon_op_e`):
  - `ASCON_OP_WR`: state word written at the clock edge where en&valid.
  - `ASCON_OP_RD`: result_o = word.
  - `ASCON_OP_CLR`: all 320 bits zeroed at the edge.
  - `ASCON_OP_PERM`: n = min(operand_a_i[3:0], RoundsMax) rounds.
- Round r of n (r = 0..n-1) uses constant index k = 12-n+r, with c = {(4'hF-k), k[3:0]}.
- Round function, all on 64-bit lanes:
  - Constant: x2 ^= c.
  - S-box: x0^=x4; x4^=x3; x2^=x1; t_j = ~x_j & x_{(j+1)mod5}; x_j ^= t_{(j+1)mod5}; x1^=x0; x0^=x4; x3^=x2; x2=~x2.
  - Linear layer (ror): x0 ^= ror19 ^ ror28; x1: 61, 39; x2: 1, 6; x3: 10, 17; x4: 7, 41.
- FSM states: IDLE, PERM, DONE.
  - IDLE & en & PERM & n>0: apply round 0 at the edge; load round counter r=1. Go to PERM if n>1, else DONE.
  - IDLE & en & PERM & n=0: valid_o combinationally in the same cycle; state unchanged; stay in IDLE.
  - PERM: apply round r at each edge; r++. After the edge applying round n-1, go to DONE. The latched n and counter do not depend on operands after the first edge.
  - DONE: valid_o=1 for one cycle; go to IDLE unconditionally.
- WR/RD/CLR in IDLE: valid_o=en combinationally; single cycle; no state change to the FSM.
- Abort: en low in PERM → IDLE at the next edge, no round applied that edge. The state keeps all rounds already completed; valid_o is not raised.
- Ops other than PERM arriving while busy: not issued by the core; ignored. The unit asserts this in simulation.

## Timing

- Reset values: state 0, FSM IDLE, counter 0, valid_o 0, result_o 0, busy_o 0.
- Latency:
  - WR/RD/CLR: 0 cycles (valid in the request cycle).
  - PERM n>0: valid_o in cycle n, counting the request cycle as 0.
  - busy_o high in cycles 0..n-1 (combinational in cycle 0) and low in DONE.
- Write data visible to RD from the cycle after the WR edge.
- Counter width 4 bits; no wrap because n ≤ 12.
- Reset mid-PERM: immediate return to the reset values above.
- Critical path: one round (sbox plus two rotates, XOR3) per cycle.

## Structure

- `ibex_pkg` gets:
  - `typedef enum logic [1:0] {ASCON_OP_WR, ASCON_OP_RD, ASCON_OP_PERM, ASCON_OP_CLR} ascon_op_e`.
  - `parameter int unsigned ASCON_ROUNDS_MAX = 12`.
  - Decoder funct3→`ascon_op_e` mapping.
- Sub-module `ibex_ascon_round`: purely combinational, 320-bit state plus 4-bit k in, 320-bit state out. Instantiated once.
- Top level holds the state register, FSM, counter and word mux.

## Test plan

- WR idx 3 ← 0xDEADBEEF, then RD idx 3 → 0xDEADBEEF. RD idx 12 → 0x00000000. WR idx 12 leaves all ten words unchanged.
- CLR, then PERM n=1 (k=11, c=0x4B) → valid_o in cycle 1, busy_o in cycle 0 only. Then RD:
  - word0 = 0x0000004B, word1 = 0x000964B0
  - word6 = 0x0000004B, word7 = 0x12E58000
  - word8 = word9 = 0
- PERM n=0 → valid_o in the request cycle, busy_o 0, all words unchanged. PERM with operand_a[3:0]=15 → 12 rounds, valid in cycle 12.
- CLR, then PERM n=12 → busy_o high cycles 0..11, valid_o in cycle 12 only. All ten words match the C golden model.
- PERM n=12 with en dropped in cycle 3 → IDLE in cycle 4, valid_o never high. State equals the golden model after rounds k=0,1,2.
- Assert rst_ni in cycle 5 of a PERM → all outputs 0 immediately; all words read 0 after reset release.
